// File: rtl/comms_pkg.sv
// Shared comms-path definitions: read-mode selectors for fifo_ext.
package comms_pkg;
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read by address.
module fifo_mem
    import comms_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             write_en,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_addr,
    output logic [WIDTH-1:0] read_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];
endmodule

// File: rtl/fifo_ext.sv
// Parametrised synchronous FIFO with registered or fall-through read, thresholds,
// occupancy count, flush and sticky overflow/underflow flags.
module fifo_ext
    import comms_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int FWFT     = FIFO_MODE_REG,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_errors
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0] out_dat;
    logic             out_vld;
    logic             rd_ok;
    logic             wr_ok;
    logic             mem_we;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign rd_ok  = read && (cnt != '0);
    assign wr_ok  = write && ((cnt != DEPTH_C) || rd_ok);
    assign mem_we = wr_ok && !flush && !reset;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock      (clock),
        .write_en   (mem_we),
        .write_addr (tail),
        .write_data (data_in),
        .read_addr  (head),
        .read_data  (mem_rd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            out_vld   <= 1'b0;
            out_dat   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            out_vld   <= 1'b0;
            overflow  <= overflow & ~clear_errors;
            underflow <= underflow & ~clear_errors;
        end else begin
            if (rd_ok) begin
                head    <= next_ptr(head);
                out_dat <= mem_rd;
            end
            if (wr_ok) begin
                tail <= next_ptr(tail);
            end
            cnt       <= cnt + CW'(wr_ok) - CW'(rd_ok);
            out_vld   <= rd_ok;
            // A rejection in the same cycle as clear_errors keeps the flag set.
            overflow  <= (write & ~wr_ok) | (overflow & ~clear_errors);
            underflow <= (read & ~rd_ok) | (underflow & ~clear_errors);
        end
    end

    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_empty = (32'(cnt) <= AE_LEVEL);
    assign almost_full  = (32'(cnt) >= AF_LEVEL);

    // Fall-through output is forced to zero when empty so reset leaves data_out at 0.
    assign data_out_valid = (FWFT == FIFO_MODE_FWFT) ? !empty : out_vld;
    assign data_out       = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : mem_rd) : out_dat;
endmodule
